te_dark_scaler: RTL and testbench

- Stage directly upstream of the transmission subtractor. Produces ω·min(Pc/Ac) in Q0.14, which the subtractor consumes to form T(x).
- Once per frame, latches atmospheric light A = (A_R, A_G, A_B) and computes per-channel reciprocals with a sequential restoring divider.
- Then streams pixels through a 3-stage pipeline: normalise each channel, take the minimum, scale by ω.

---
 rtl/te_dark_scaler.sv | 193 +++++++++++++++++++
 tb/tb_te_dark_scaler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_dark_scaler.sv
// te_dark_scaler: reciprocal divider plus 3-stage pixel pipeline producing w*min(Pc/Ac) in Q0.14.
// Ports: clk, rst_n, a_load/a_r/a_g/a_b (A capture), in_valid/in_ready/p_* (pixels), out_valid/out_t_min.
module te_dark_scaler #(
  parameter logic [13:0] OMEGA      = 14'd15565,
  parameter int          RECIP_BITS = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_load,
  input  logic [7:0]  a_r,
  input  logic [7:0]  a_g,
  input  logic [7:0]  a_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  p_r,
  input  logic [7:0]  p_g,
  input  logic [7:0]  p_b,
  output logic        out_valid,
  output logic [13:0] out_t_min
);

  localparam int PW = 8 + RECIP_BITS;
  localparam logic [4:0] LAST = 5'(RECIP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    DIV_R,
    DIV_G,
    DIV_B,
    READY
  } state_t;

  state_t state;

  logic [7:0] cap_r;
  logic [7:0] cap_g;
  logic [7:0] cap_b;
  logic [4:0] cnt;
  logic [7:0] rem;
  logic [RECIP_BITS-1:0] quo;
  logic [RECIP_BITS-1:0] wrk_r;
  logic [RECIP_BITS-1:0] wrk_g;
  logic [RECIP_BITS-1:0] act_r;
  logic [RECIP_BITS-1:0] act_g;
  logic [RECIP_BITS-1:0] act_b;

  logic [7:0] dsr;
  logic       dbit;
  logic [8:0] trial;
  logic       ge;
  logic [8:0] nrem;
  logic [RECIP_BITS-1:0] qnext;

  always_comb begin
    dsr = cap_r;
    unique case (1'b1)
      (state == DIV_G): dsr = cap_g;
      (state == DIV_B): dsr = cap_b;
      default:          dsr = cap_r;
    endcase
  end

  // Dividend is 2^22: only the first step shifts in a one.
  assign dbit  = (cnt == 5'd0);
  assign trial = {rem, dbit};
  assign ge    = (trial >= {1'b0, dsr});
  assign nrem  = ge ? (trial - {1'b0, dsr}) : trial;
  assign qnext = (quo << 1) |
                 {{(RECIP_BITS-1){1'b0}}, ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_r    <= '0;
      cap_g    <= '0;
      cap_b    <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      wrk_r    <= '0;
      wrk_g    <= '0;
      act_r    <= '0;
      act_g    <= '0;
      act_b    <= '0;
      in_ready <= 1'b0;
    end else if (a_load) begin
      // Zero light would divide by zero; treat it as one.
      cap_r    <= (a_r == 8'd0) ? 8'd1 : a_r;
      cap_g    <= (a_g == 8'd0) ? 8'd1 : a_g;
      cap_b    <= (a_b == 8'd0) ? 8'd1 : a_b;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      in_ready <= 1'b0;
      state    <= DIV_R;
    end else begin
      unique case (state)
        DIV_R, DIV_G, DIV_B: begin
          if (cnt == LAST) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            unique case (state)
              DIV_R: begin
                wrk_r <= qnext;
                state <= DIV_G;
              end
              DIV_G: begin
                wrk_g <= qnext;
                state <= DIV_B;
              end
              default: begin
                // Blue's working value is the final quotient itself.
                act_r    <= wrk_r;
                act_g    <= wrk_g;
                act_b    <= qnext;
                in_ready <= 1'b1;
                state    <= READY;
              end
            endcase
          end else begin
            cnt <= cnt + 5'd1;
            rem <= 8'(nrem);
            quo <= qnext;
          end
        end
        READY:   in_ready <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [13:0] sat14(
    input logic [PW-1:0] p
  );
    logic [PW-9:0] s;
    s = (PW-8)'(p >> 8);
    return (|s[PW-9:14]) ? 14'h3fff : s[13:0];
  endfunction

  logic [PW-1:0] pr_r;
  logic [PW-1:0] pr_g;
  logic [PW-1:0] pr_b;

  assign pr_r = {{RECIP_BITS{1'b0}}, p_r} * {8'h00, act_r};
  assign pr_g = {{RECIP_BITS{1'b0}}, p_g} * {8'h00, act_g};
  assign pr_b = {{RECIP_BITS{1'b0}}, p_b} * {8'h00, act_b};

  logic        acc;
  logic        s1_v;
  logic [13:0] s1_r;
  logic [13:0] s1_g;
  logic [13:0] s1_b;
  logic        s2_v;
  logic [13:0] s2_m;
  logic [13:0] mn;
  logic [27:0] sc;

  assign acc = in_valid && in_ready;

  always_comb begin
    mn = s1_r;
    if (s1_g < mn) mn = s1_g;
    if (s1_b < mn) mn = s1_b;
  end

  assign sc = {14'd0, s2_m} * {14'd0, OMEGA};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s2_v      <= 1'b0;
      s2_m      <= '0;
      out_valid <= 1'b0;
      out_t_min <= '0;
    end else begin
      s1_v      <= acc;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      if (acc) begin
        s1_r <= sat14(pr_r);
        s1_g <= sat14(pr_g);
        s1_b <= sat14(pr_b);
      end
      if (s1_v) s2_m <= mn;
      if (s2_v) out_t_min <= 14'(sc >> 14);
    end
  end

endmodule

// File: tb/tb_te_dark_scaler.sv
// Directed bench for te_dark_scaler.
// Drives and samples on the falling edge.
module tb_te_dark_scaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_load;
  logic [7:0]  a_r, a_g, a_b;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  p_r, p_g, p_b;
  logic        out_valid;
  logic [13:0] out_t_min;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  te_dark_scaler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_load    (a_load),
    .a_r       (a_r),
    .a_g       (a_g),
    .a_b       (a_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_r       (p_r),
    .p_g       (p_g),
    .p_b       (p_b),
    .out_valid (out_valid),
    .out_t_min (out_t_min)
  );

  function automatic int ref_out(input int pr, pg, pb, ar, ag, ab);
    int ir, ig, ib, rr, rg, rb, m;
    ir = 4194304 / ((ar == 0) ? 1 : ar);
    ig = 4194304 / ((ag == 0) ? 1 : ag);
    ib = 4194304 / ((ab == 0) ? 1 : ab);
    rr = (pr * ir) >> 8;
    rg = (pg * ig) >> 8;
    rb = (pb * ib) >> 8;
    if (rr > 16383) rr = 16383;
    if (rg > 16383) rg = 16383;
    if (rb > 16383) rb = 16383;
    m = rr;
    if (rg < m) m = rg;
    if (rb < m) m = rb;
    return (m * 15565) >> 14;
  endfunction

  task automatic load_and_wait(input logic [7:0] r, g, b,
                               input int exp_n, input string nm);
    int n;
    n = 0;
    a_load = 1'b1;
    a_r = r;
    a_g = g;
    a_b = b;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      a_load = 1'b0;
      n = k;
      if (in_ready) break;
    end
    checks++;
    if (n !== exp_n || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_latency got %0d ready=%b want %0d",
               nm, n, in_ready, exp_n);
    end
  endtask

  task automatic pixel(input logic [7:0] r, g, b,
                       input logic [13:0] exp, input string nm);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready got %b want 1", nm, in_ready);
    end
    p_r = r;
    p_g = g;
    p_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid got %b want 0", nm, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_t_min !== exp) begin
      errors++;
      $display("FAIL %s result got v=%b %0d want v=1 %0d",
               nm, out_valid, out_t_min, exp);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_t_min !== exp) begin
      errors++;
      $display("FAIL %s hold got v=%b %0d want v=0 %0d",
               nm, out_valid, out_t_min, exp);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    a_load = 1'b0;
    a_r = 8'd0;
    a_g = 8'd0;
    a_b = 8'd0;
    p_r = 8'd9;
    p_g = 8'd9;
    p_b = 8'd9;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_t_min !== 14'd0) begin
      errors++;
      $display("FAIL reset got r=%b v=%b t=%0d want 0 0 0",
               in_ready, out_valid, out_t_min);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_t_min !== 14'd0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle got %0d nonzero cycles want 0", bad);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_nominal();
    load_and_wait(8'd255, 8'd255, 8'd255, 70, "nominal");
    checks++;
    if (dut.act_r !== 23'd16448 || dut.act_b !== 23'd16448) begin
      errors++;
      $display("FAIL nominal_inv got %0d %0d want 16448",
               dut.act_r, dut.act_b);
    end
    pixel(8'd255, 8'd255, 8'd255, 14'd15564, "nominal");
  endtask

  task automatic test_mixed();
    load_and_wait(8'd200, 8'd100, 8'd50, 70, "mixed");
    p_r = 8'd100;
    p_g = 8'd100;
    p_b = 8'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (dut.s1_r !== 14'd8191 || dut.s1_g !== 14'd16383 ||
        dut.s1_b !== 14'd16383) begin
      errors++;
      $display("FAIL mixed_ratio got %0d %0d %0d want 8191 16383 16383",
               dut.s1_r, dut.s1_g, dut.s1_b);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_t_min !== 14'd7781) begin
      errors++;
      $display("FAIL mixed got v=%b %0d want v=1 7781",
               out_valid, out_t_min);
    end
    @(negedge clk);
    pixel(8'd0, 8'd0, 8'd0, 14'd0, "black");
  endtask

  task automatic test_clamp();
    load_and_wait(8'd0, 8'd255, 8'd255, 70, "clamp");
    checks++;
    if (dut.act_r !== 23'd4194304) begin
      errors++;
      $display("FAIL clamp_inv got %0d want 4194304", dut.act_r);
    end
    pixel(8'd1, 8'd255, 8'd255, 14'd15564, "clamp");
  endtask

  task automatic test_back_to_back();
    bit exp_v [0:511];
    int exp_d [0:511];
    int i, ts, last;
    bit strobed;
    int pr, pg, pb;
    load_and_wait(8'd200, 8'd100, 8'd50, 70, "stream_a1");
    i = 0;
    ts = -1000;
    last = 0;
    strobed = 1'b0;
    for (int t = 0; t < 450; t++) begin
      if (t >= 3) begin
        checks++;
        if (out_valid !== exp_v[t-3] ||
            (exp_v[t-3] && out_t_min !== 14'(exp_d[t-3]))) begin
          errors++;
          $display("FAIL stream t=%0d got v=%b %0d want v=%b %0d",
                   t, out_valid, out_t_min, exp_v[t-3], exp_d[t-3]);
        end
      end
      if (t == ts + 1 || t == ts + 69 || t == ts + 70) begin
        checks++;
        if (in_ready !== (t == ts + 70)) begin
          errors++;
          $display("FAIL stream_ready t=%0d got %b want %b",
                   t - ts, in_ready, (t == ts + 70));
        end
      end
      if (i >= 100 && t >= last + 4) break;
      a_load = 1'b0;
      pr = (i * 37 + 11) & 255;
      pg = (i * 53 + 7) & 255;
      pb = (i * 91 + 3) & 255;
      p_r = 8'(pr);
      p_g = 8'(pg);
      p_b = 8'(pb);
      in_valid = (i < 100);
      if (i == 50 && !strobed && in_ready) begin
        a_load = 1'b1;
        a_r = 8'd90;
        a_g = 8'd180;
        a_b = 8'd240;
        strobed = 1'b1;
        ts = t;
      end
      exp_v[t] = in_valid && in_ready;
      exp_d[t] = 0;
      if (exp_v[t]) begin
        if (strobed && t > ts)
          exp_d[t] = ref_out(pr, pg, pb, 90, 180, 240);
        else
          exp_d[t] = ref_out(pr, pg, pb, 200, 100, 50);
        i++;
        last = t;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    a_load = 1'b0;
    checks++;
    if (i != 100) begin
      errors++;
      $display("FAIL stream_count got %0d want 100", i);
    end
  endtask

  task automatic test_restart();
    a_load = 1'b1;
    a_r = 8'd10;
    a_g = 8'd20;
    a_b = 8'd30;
    @(negedge clk);
    a_load = 1'b0;
    repeat (29) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_busy got %b want 0", in_ready);
    end
    load_and_wait(8'd200, 8'd100, 8'd50, 70, "restart");
    pixel(8'd100, 8'd100, 8'd100, 14'd7781, "restart");
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    a_load = 1'b1;
    a_r = 8'd255;
    a_g = 8'd255;
    a_b = 8'd255;
    @(negedge clk);
    a_load = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_t_min !== 14'd0 ||
        dut.act_r !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid got r=%b v=%b t=%0d inv=%0d want 0",
               in_ready, out_valid, out_t_min, dut.act_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle got %0d busy cycles want 0", bad);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_mixed();
    test_clamp();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
